// File: rtl/fwd_hazard_tracker.sv
// Forwarding-select and load-use stall unit: tracks the DEPTH most recent register
// writers in a shift record and picks the youngest producer for each ID source.
module fwd_hazard_tracker #(
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int SELW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic [NSRC*REG_AW-1:0] id_rs,
    input  logic                   flush,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall,
    output logic [CNT_W-1:0]       stall_count
);

    logic [DEPTH-1:0]  entVldReg;
    logic [DEPTH-1:0]  entLdReg;
    logic [REG_AW-1:0] entRdReg [DEPTH];
    logic [CNT_W-1:0]  stallCountReg;
    logic [NSRC-1:0]   srcHazard;
    logic              newVld;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [REG_AW-1:0] rsVal;
        logic [SELW-1:0]   selVal;
        logic              hazVal;

        assign rsVal = id_rs[gi*REG_AW +: REG_AW];

        // Scan oldest to youngest so the youngest match overwrites older ones.
        always_comb begin
            selVal = '0;
            hazVal = 1'b0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (entVldReg[i] && (entRdReg[i] == rsVal) && (rsVal != '0)) begin
                    selVal = SELW'(i + 1);
                    hazVal = entLdReg[i] && (i < LOAD_LAT);
                end
            end
        end

        assign fwd_sel[gi*SELW +: SELW] = selVal;
        assign srcHazard[gi]            = hazVal;
    end

    assign stall       = id_valid & ~flush & (|srcHazard);
    assign newVld      = id_valid & id_regwrite & (id_rd != '0) & ~stall & ~flush;
    assign stall_count = stallCountReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            entVldReg     <= '0;
            entLdReg      <= '0;
            stallCountReg <= '0;
        end else begin
            entVldReg[0] <= newVld;
            entLdReg[0]  <= id_is_load;
            entRdReg[0]  <= id_rd;
            // Downstream stages never stall, so the record always advances.
            for (int i = 1; i < DEPTH; i++) begin
                entVldReg[i] <= entVldReg[i-1];
                entLdReg[i]  <= entLdReg[i-1];
                entRdReg[i]  <= entRdReg[i-1];
            end
            if (stall && (stallCountReg != '1)) begin
                stallCountReg <= stallCountReg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Bench for fwd_hazard_tracker: directed scenarios plus random traffic checked
// against a slot-list reference model; a second instance uses a 4-bit counter.
module tb_fwd_hazard_tracker;
    localparam int NSRC = 2, DEPTH = 3, REG_AW = 5, LOAD_LAT = 1, SELW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, id_regwrite = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic [REG_AW-1:0] id_rd = '0;
    logic [NSRC*REG_AW-1:0] id_rs = '0;
    logic [NSRC*SELW-1:0] selA, selB;
    logic stallA, stallB;
    logic [15:0] cntA;
    logic [3:0]  cntB;

    always #5 clk = ~clk;

    fwd_hazard_tracker #(.NSRC(NSRC), .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_rd(id_rd), .id_rs(id_rs), .flush(flush),
        .fwd_sel(selA), .stall(stallA), .stall_count(cntA));

    fwd_hazard_tracker #(.NSRC(NSRC), .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_regwrite(id_regwrite),
        .id_is_load(id_is_load), .id_rd(id_rd), .id_rs(id_rs), .flush(flush),
        .fwd_sel(selB), .stall(stallB), .stall_count(cntB));

    // Reference model: list of recent writers, index 0 = most recent
    bit mV [DEPTH];
    int mRd[DEPTH];
    bit mL [DEPTH];
    int mCntA, mCntB;
    int checks = 0, errors = 0;
    int obsSel0, obsSel1, obsStall, obsCntA, obsCntB;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void modelClear();
        for (int i = 0; i < DEPTH; i++) begin mV[i] = 0; mRd[i] = 0; mL[i] = 0; end
        mCntA = 0; mCntB = 0;
    endfunction

    // Youngest writer of rs wins; it is a hazard only if it is a load not yet forwardable.
    function automatic void modelLookup(input int rs, output int sel, output bit haz);
        sel = 0; haz = 0;
        if (rs != 0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mV[i] && mRd[i] == rs) begin
                    sel = i + 1;
                    haz = mL[i] && (i < LOAD_LAT);
                    break;
                end
            end
        end
    endfunction

    task automatic doCycle(input bit v, input bit rw, input bit ld, input int rd,
                           input int rs0, input int rs1, input bit fl);
        int s0, s1;
        bit h0, h1, expStall;
        id_valid = v; id_regwrite = rw; id_is_load = ld; flush = fl;
        id_rd = REG_AW'(rd);
        id_rs = {REG_AW'(rs1), REG_AW'(rs0)};
        @(negedge clk);
        modelLookup(rs0, s0, h0);
        modelLookup(rs1, s1, h1);
        expStall = v && !fl && (h0 || h1);
        obsSel0 = int'(selA[SELW-1:0]); obsSel1 = int'(selA[2*SELW-1:SELW]);
        obsStall = int'(stallA); obsCntA = int'(cntA); obsCntB = int'(cntB);
        if (!expStall) begin
            check("fwd_sel0", obsSel0, s0);
            check("fwd_sel1", obsSel1, s1);
            check("fwd_selB", int'(selB), int'(selA));
        end
        check("stall", obsStall, int'(expStall));
        check("stallB", int'(stallB), int'(expStall));
        check("stall_count", obsCntA, mCntA);
        check("stall_count4", obsCntB, mCntB);
        $display("cyc v=%0b rw=%0b ld=%0b rd=%0d rs=%0d,%0d fl=%0b rst=%0b -> sel=%0d,%0d stall=%0b cnt=%0d/%0d",
                 v, rw, ld, rd, rs0, rs1, fl, rst, obsSel0, obsSel1, obsStall, obsCntA, obsCntB);
        @(posedge clk);
        if (rst) modelClear();
        else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mV[i] = mV[i-1]; mRd[i] = mRd[i-1]; mL[i] = mL[i-1];
            end
            mV[0] = v && rw && (rd != 0) && !expStall && !fl;
            mRd[0] = rd; mL[0] = ld;
            if (expStall) begin
                if (mCntA < 65535) mCntA++;
                if (mCntB < 15) mCntB++;
            end
        end
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelClear();
    endtask

    initial begin
        modelClear();
        doReset();
        // Reset state
        doCycle(0, 0, 0, 0, 0, 0, 0);
        check("rst_sel", obsSel0 + obsSel1, 0);
        check("rst_stall", obsStall, 0);
        check("rst_cnt", obsCntA, 0);

        // Back-to-back ALU
        doCycle(1, 1, 0, 5, 1, 2, 0);
        doCycle(1, 1, 0, 6, 5, 3, 0);
        check("b2b_sel0", obsSel0, 1);
        check("b2b_stall", obsStall, 0);

        // Distance 2
        doCycle(1, 1, 0, 5, 1, 2, 0);
        doCycle(1, 1, 0, 10, 3, 4, 0);
        doCycle(1, 1, 0, 11, 1, 5, 0);
        check("d2_sel1", obsSel1, 2);
        check("d2_sel0", obsSel0, 0);

        // Load-use
        doCycle(1, 1, 1, 7, 1, 0, 0);
        doCycle(1, 1, 0, 8, 7, 7, 0);
        check("lu_stall", obsStall, 1);
        doCycle(1, 1, 0, 8, 7, 7, 0);
        check("lu_sel0", obsSel0, 2);
        check("lu_sel1", obsSel1, 2);
        check("lu_stall_after", obsStall, 0);
        check("lu_cnt", obsCntA, 1);

        // Priority and x0
        doCycle(1, 1, 1, 9, 1, 0, 0);
        doCycle(1, 1, 0, 9, 9, 0, 0);
        check("prio_stall", obsStall, 1);
        doCycle(1, 1, 0, 9, 9, 0, 0);
        doCycle(1, 1, 0, 12, 9, 0, 0);
        check("prio_sel", obsSel0, 1);
        check("prio_stall2", obsStall, 0);
        doCycle(1, 1, 0, 0, 3, 3, 0);
        doCycle(1, 1, 0, 4, 0, 0, 0);
        check("x0_sel", obsSel0, 0);

        // Flush dominates a load-use hazard
        doCycle(1, 1, 1, 7, 0, 0, 0);
        doCycle(1, 1, 0, 8, 7, 0, 1);
        check("flush_stall", obsStall, 0);
        doCycle(1, 1, 0, 8, 7, 0, 0);
        check("flush_sel", obsSel0, 2);
        check("flush_stall2", obsStall, 0);

        // Reset in the middle of a stall
        doCycle(1, 1, 1, 7, 0, 0, 0);
        rst = 1'b1;
        doCycle(1, 1, 0, 8, 7, 0, 0);
        check("mid_rst_stall", obsStall, 1);
        rst = 1'b0;
        doCycle(1, 1, 0, 8, 7, 0, 0);
        check("post_rst_stall", obsStall, 0);
        check("post_rst_sel", obsSel0, 0);
        check("post_rst_cnt", obsCntA, 0);

        // Counter saturation on the 4-bit instance
        for (int k = 0; k < 20; k++) begin
            doCycle(1, 1, 1, 7, 0, 0, 0);
            doCycle(1, 1, 0, 8, 7, 0, 0);
            doCycle(1, 1, 0, 8, 7, 0, 0);
        end
        check("sat_cnt4", obsCntB, 15);
        check("sat_cnt16", obsCntA, 20);

        // Random traffic against the model
        doReset();
        for (int k = 0; k < 600; k++) begin
            doCycle($urandom_range(9, 0) != 0, $urandom_range(4, 0) != 0,
                    $urandom_range(2, 0) == 0, int'($urandom_range(7, 0)),
                    int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                    $urandom_range(9, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
